// File: rtl/phy_len_tracker.sv
// Follows decode progress of one packet against the PHY length.
// Flags the last symbol, the final data bit and length faults.
module phy_len_tracker #(
  parameter int MAX_NDBPS = 260
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        pkt_abort,
  input  logic        phy_len_valid,
  input  logic [14:0] n_ofdm_sym,
  input  logic [19:0] n_bit_in_last_sym,
  input  logic        sym_done,
  input  logic        bit_valid,
  output logic [14:0] sym_cnt,
  output logic        last_sym,
  output logic [8:0]  bits_left,
  output logic        decode_done,
  output logic        len_error,
  output logic        sym_overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [14:0] n_sym;
  logic [8:0]  n_bits;

  logic        len_bad;
  logic        sym_hit;
  logic        sym_sat;
  logic [14:0] sym_nxt;
  logic [14:0] n_sym_m1;

  assign len_bad  = (n_ofdm_sym == 15'd0)
                 || (n_bit_in_last_sym == 20'd0)
                 || (n_bit_in_last_sym > 20'(MAX_NDBPS));
  assign sym_hit  = (sym_cnt == n_sym);
  assign sym_sat  = (sym_cnt == 15'h7fff);
  assign sym_nxt  = sym_cnt + 15'd1;
  assign n_sym_m1 = n_sym - 15'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      n_sym       <= '0;
      n_bits      <= '0;
      sym_cnt     <= '0;
      last_sym    <= 1'b0;
      bits_left   <= '0;
      decode_done <= 1'b0;
      len_error   <= 1'b0;
      sym_overrun <= 1'b0;
      busy        <= 1'b0;
    end else if (pkt_abort) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      last_sym    <= 1'b0;
      bits_left   <= '0;
      decode_done <= 1'b0;
      busy        <= 1'b0;
    end else if (!enable) begin
      decode_done <= 1'b0;
    end else begin
      decode_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (phy_len_valid) begin
            n_sym   <= n_ofdm_sym;
            n_bits  <= n_bit_in_last_sym[8:0];
            sym_cnt <= '0;
            if (len_bad) begin
              len_error <= 1'b1;
              state     <= DONE;
            end else begin
              len_error   <= 1'b0;
              sym_overrun <= 1'b0;
              busy        <= 1'b1;
              if (n_ofdm_sym == 15'd1) begin
                state     <= LAST;
                last_sym  <= 1'b1;
                bits_left <= n_bit_in_last_sym[8:0];
              end else begin
                state <= TRACK;
              end
            end
          end
        end
        TRACK: begin
          // A bit arriving with the symbol that enters LAST is dropped.
          if (sym_done) begin
            if (sym_hit) begin
              sym_overrun <= 1'b1;
            end else begin
              sym_cnt <= sym_nxt;
              if (sym_nxt == n_sym_m1) begin
                state     <= LAST;
                last_sym  <= 1'b1;
                bits_left <= n_bits;
              end
            end
          end
        end
        LAST: begin
          if (sym_done) begin
            if (sym_hit)       sym_overrun <= 1'b1;
            else if (!sym_sat) sym_cnt     <= sym_nxt;
          end
          if (bit_valid && bits_left != 9'd0) begin
            bits_left <= bits_left - 9'd1;
            if (bits_left == 9'd1) begin
              decode_done <= 1'b1;
              last_sym    <= 1'b0;
              busy        <= 1'b0;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (sym_done) begin
            if (sym_hit)       sym_overrun <= 1'b1;
            else if (!sym_sat) sym_cnt     <= sym_nxt;
          end
          if (!phy_len_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_len_tracker.sv
// Directed and randomized checks of phy_len_tracker.
// Reference model counts symbols and bits per packet.
module tb_phy_len_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        pkt_abort = 1'b0;
  logic        phy_len_valid = 1'b0;
  logic [14:0] n_ofdm_sym = '0;
  logic [19:0] n_bit_in_last_sym = '0;
  logic        sym_done = 1'b0;
  logic        bit_valid = 1'b0;
  logic [14:0] sym_cnt;
  logic        last_sym;
  logic [8:0]  bits_left;
  logic        decode_done;
  logic        len_error;
  logic        sym_overrun;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int dones = 0;

  phy_len_tracker #(.MAX_NDBPS(260)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .pkt_abort(pkt_abort), .phy_len_valid(phy_len_valid),
    .n_ofdm_sym(n_ofdm_sym), .n_bit_in_last_sym(n_bit_in_last_sym),
    .sym_done(sym_done), .bit_valid(bit_valid),
    .sym_cnt(sym_cnt), .last_sym(last_sym), .bits_left(bits_left),
    .decode_done(decode_done), .len_error(len_error),
    .sym_overrun(sym_overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  // model: a captured packet, symbols seen, bits counted in the last symbol
  bit m_pkt = 0;
  int m_n = 0;
  int m_b = 0;
  int m_syms = 0;
  int m_bits = 0;
  bit m_lerr = 0;
  bit m_ovr = 0;
  bit m_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pkt = 0; m_n = 0; m_b = 0; m_syms = 0; m_bits = 0;
    m_lerr = 0; m_ovr = 0; m_pulse = 0;
  endtask

  task automatic model_edge();
    bit fin;
    int sb;
    if (pkt_abort) begin
      m_pkt = 0; m_syms = 0; m_bits = 0; m_pulse = 0;
    end else if (!enable) begin
      m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (!m_pkt) begin
        if (phy_len_valid) begin
          m_n = int'(n_ofdm_sym);
          m_b = int'(n_bit_in_last_sym);
          m_syms = 0;
          m_bits = 0;
          m_lerr = (m_n == 0) || (m_b == 0) || (m_b > 260);
          if (!m_lerr) m_ovr = 0;
          m_pkt = 1;
        end
      end else begin
        fin = m_lerr || (m_bits == m_b);
        sb = m_syms;
        if (sym_done) begin
          if (sb >= m_n) m_ovr = 1;
          else m_syms++;
        end
        if (bit_valid && !m_lerr && sb >= m_n - 1 && m_bits < m_b) begin
          m_bits++;
          if (m_bits == m_b) m_pulse = 1;
        end
        if (fin && !phy_len_valid) m_pkt = 0;
      end
    end
  endtask

  task automatic check_all();
    bit e_last;
    bit e_busy;
    e_busy = m_pkt && !m_lerr && (m_bits < m_b);
    e_last = e_busy && (m_syms >= m_n - 1);
    chk("sym_cnt", 32'(sym_cnt), 32'((m_syms < m_n) ? m_syms : m_n));
    chk("last_sym", 32'(last_sym), 32'(e_last));
    chk("bits_left", 32'(bits_left), 32'(e_last ? m_b - m_bits : 0));
    chk("decode_done", 32'(decode_done), 32'(m_pulse));
    chk("len_error", 32'(len_error), 32'(m_lerr));
    chk("sym_overrun", 32'(sym_overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'(e_busy));
    if (decode_done === 1'b1) dones++;
  endtask

  task automatic step(input bit sd, input bit bv);
    sym_done = sd;
    bit_valid = bv;
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    sym_done = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic start(input int n, input int b);
    n_ofdm_sym = 15'(n);
    n_bit_in_last_sym = 20'(b);
    phy_len_valid = 1'b1;
    step(0, 0);
  endtask

  task automatic finish_pkt();
    phy_len_valid = 1'b0;
    step(0, 0);
    step(0, 0);
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) step(0, 0);
  endtask

  task automatic syms(input int k);
    for (int i = 0; i < k; i++) begin
      gap();
      step(1, 0);
    end
  endtask

  task automatic bits(input int k);
    for (int i = 0; i < k; i++) begin
      gap();
      step(0, 1);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    reset = 1'b1;
    step(0, 0);

    // three symbols, 100 bits in the last one
    dones = 0;
    start(3, 100);
    syms(2);
    chk("t1_last_after_2", 32'(last_sym), 32'd1);
    bits(100);
    step(0, 0);
    chk("t1_one_done", 32'(dones), 32'd1);
    chk("t1_sym_cnt", 32'(sym_cnt), 32'd2);
    finish_pkt();

    // single symbol, overrun on second sym_done
    start(1, 24);
    chk("t2_bits_left", 32'(bits_left), 32'd24);
    bits(24);
    syms(2);
    chk("t2_overrun", 32'(sym_overrun), 32'd1);
    finish_pkt();

    // length errors, then a good packet clears them
    dones = 0;
    start(4, 261);
    syms(1);
    finish_pkt();
    start(0, 10);
    finish_pkt();
    chk("t3_no_done", 32'(dones), 32'd0);
    start(2, 5);
    chk("t3_err_clear", 32'(len_error), 32'd0);
    syms(1);
    bits(5);
    finish_pkt();

    // abort in LAST with 50 bits left
    dones = 0;
    start(2, 80);
    syms(1);
    bits(30);
    chk("t4_left50", 32'(bits_left), 32'd50);
    pkt_abort = 1'b1;
    step(0, 1);
    pkt_abort = 1'b0;
    chk("t4_no_done", 32'(dones), 32'd0);
    finish_pkt();
    start(2, 7);
    syms(1);
    bits(7);
    finish_pkt();

    // same-cycle sym_done and bit_valid on entry to LAST
    start(3, 60);
    syms(1);
    step(1, 1);
    chk("t5_full_left", 32'(bits_left), 32'd60);
    bits(60);
    finish_pkt();

    // enable low holds state and truncates decode_done
    start(2, 3);
    syms(1);
    bits(2);
    enable = 1'b0;
    step(1, 1);
    step(0, 1);
    enable = 1'b1;
    step(0, 1);
    enable = 1'b0;
    step(0, 0);
    enable = 1'b1;
    finish_pkt();

    // asynchronous reset in the middle of LAST
    start(1, 40);
    bits(10);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #2;
    reset = 1'b1;
    phy_len_valid = 1'b0;
    step(0, 0);

    // randomized packets with enable dropouts
    for (int p = 0; p < 4; p++) begin
      int cyc;
      start($urandom_range(1, 4), $urandom_range(1, 260));
      cyc = 0;
      while ((m_bits < m_b) && cyc < 3000) begin
        enable = ($urandom_range(0, 9) != 0);
        step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        cyc++;
      end
      enable = 1'b1;
      chk("rand_timeout", 32'(cyc < 3000), 32'd1);
      finish_pkt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
